// File: rtl/lab_readout_seq_pkg.sv
// Shared definitions for the LAB readout sequencer.
// Holds the FSM state encoding, the default geometry of a readout buffer
// (channels, samples, Wilkinson width, timing), the RAM address layout and
// a lowest-index picker used to choose the next pending buffer.
package lab_readout_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CONVERT = 3'd2,
        ST_SELECT  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int NCHAN_DEF         = 12;
    localparam int NSAMP_DEF         = 256;
    localparam int DBITS_DEF         = 12;
    localparam int CONV_CYCLES_DEF   = 1024;
    localparam int SETTLE_CYCLES_DEF = 4;

    localparam int NBUF   = 4;   // LAB storage buffers
    localparam int BUF_W  = 2;
    localparam int ADDR_W = 14;  // {buffer, word-in-buffer}
    localparam int WORD_W = 12;  // word-in-buffer field
    localparam int DAT_W  = 16;  // RAM write data width
    localparam int SEL_W  = 8;   // LAB sample select width

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [BUF_W-1:0] lowest_set(input logic [NBUF-1:0] v);
        logic [BUF_W-1:0] idx;
        idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (v[i]) idx = BUF_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lab_readout_seq_tracker.sv
// lab_buf_tracker: per-buffer bookkeeping for the readout sequencer.
// Tracks which buffers have a digitize request queued (pending), which have
// been fully written (ready), and a sticky overrun flag for strobes that land
// on a buffer that is already pending, being converted, or ready.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   digitize_i        per-buffer one-cycle digitize strobes
//   clr_buf_i/clr_sel_i  ready-flag clear strobe and its buffer index
//   take_i            parent consumes the picked buffer this cycle
//   active_i/active_buf_i  parent is converting buffer active_buf_i
//   done_i            active buffer has been fully written
//   pending_any_o     some buffer is waiting
//   pick_o            lowest-index pending buffer
//   ready_o           per-buffer data-ready flags
//   overrun_o         sticky dropped-strobe flag
module lab_buf_tracker
    import lab_readout_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NBUF-1:0]  digitize_i,
    input  logic             clr_buf_i,
    input  logic [BUF_W-1:0] clr_sel_i,
    input  logic             take_i,
    input  logic             active_i,
    input  logic [BUF_W-1:0] active_buf_i,
    input  logic             done_i,
    output logic             pending_any_o,
    output logic [BUF_W-1:0] pick_o,
    output logic [NBUF-1:0]  ready_o,
    output logic             overrun_o
);

    logic [NBUF-1:0] pending_reg, pending_next;
    logic [NBUF-1:0] ready_reg, ready_next;
    logic [NBUF-1:0] collide;
    logic            overrun_reg, overrun_next;

    assign pending_any_o = |pending_reg;
    assign pick_o        = lowest_set(pending_reg);

    generate
        for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
            logic is_active;
            logic blocked;
            logic taken;
            logic set_rdy;
            logic clr_rdy;

            assign is_active = active_i && (active_buf_i == BUF_W'(gi));
            assign blocked   = pending_reg[gi] | ready_reg[gi] | is_active;
            assign collide[gi] = digitize_i[gi] & blocked;
            assign taken     = take_i && (pick_o == BUF_W'(gi));

            // A strobe is only accepted when the buffer is not pending, so
            // accept and take can never hit the same bit in one cycle.
            assign pending_next[gi] = (digitize_i[gi] & ~blocked) |
                                      (pending_reg[gi] & ~taken);

            // Set beats clear; clears aimed at a busy buffer are ignored.
            assign set_rdy = done_i && is_active;
            assign clr_rdy = clr_buf_i && (clr_sel_i == BUF_W'(gi)) &&
                             !pending_reg[gi] && !is_active;
            assign ready_next[gi] = set_rdy | (ready_reg[gi] & ~clr_rdy);
        end
    endgenerate

    assign overrun_next = overrun_reg | (|collide);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_reg <= '0;
            ready_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            ready_reg   <= ready_next;
            overrun_reg <= overrun_next;
        end
    end

    assign ready_o   = ready_reg;
    assign overrun_o = overrun_reg;

endmodule

// File: rtl/lab_readout_seq.sv
// lab_readout_seq: LAB Wilkinson conversion and readout sequencer.
// For each requested buffer: clears the Wilkinson counters, ramps for the
// conversion window, then walks every sample, settles the sample select,
// captures all channels at once and writes them one word per cycle into the
// readout RAM. A per-buffer ready flag is raised once the buffer is complete.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   digitize_i     per-buffer digitize strobes
//   clr_buf_i, clr_sel_i  ready-flag clear from the bus interface
//   lab_dat_i      parallel Wilkinson results, channel c at [c*DBITS +: DBITS]
//   ramp_o, wclr_o Wilkinson ramp enable and counter clear
//   buf_o, sel_o   buffer and sample select to the LAB
//   ram_we_o, ram_addr_o, ram_dat_o  readout RAM write port
//   ready_o, busy_o, overrun_o  status
module lab_readout_seq
    import lab_readout_seq_pkg::*;
#(
    parameter int NCHAN         = NCHAN_DEF,
    parameter int NSAMP         = NSAMP_DEF,
    parameter int DBITS         = DBITS_DEF,
    parameter int CONV_CYCLES   = CONV_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NBUF-1:0]        digitize_i,
    input  logic                   clr_buf_i,
    input  logic [BUF_W-1:0]       clr_sel_i,
    input  logic [NCHAN*DBITS-1:0] lab_dat_i,
    output logic                   ramp_o,
    output logic                   wclr_o,
    output logic [BUF_W-1:0]       buf_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic                   ram_we_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [DAT_W-1:0]       ram_dat_o,
    output logic [NBUF-1:0]        ready_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int SAMP_W  = $clog2(NSAMP);
    localparam int CH_W    = $clog2(NCHAN);
    localparam int CNT_MAX = (CONV_CYCLES > SETTLE_CYCLES) ? CONV_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SAMP_W-1:0]  samp_reg, samp_next;
    logic [CH_W-1:0]    ch_reg, ch_next;
    logic [WORD_W-1:0]  base_reg, base_next;   // ch * NSAMP, built by addition
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [BUF_W-1:0]   buf_reg, buf_next;
    logic [DBITS-1:0]   hold_reg [NCHAN];
    logic [DBITS-1:0]   lab_ch   [NCHAN];

    logic               take;
    logic               done;
    logic               pending_any;
    logic [BUF_W-1:0]   pick;

    lab_buf_tracker u_tracker (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .digitize_i    (digitize_i),
        .clr_buf_i     (clr_buf_i),
        .clr_sel_i     (clr_sel_i),
        .take_i        (take),
        .active_i      (state_reg != ST_IDLE),
        .active_buf_i  (buf_reg),
        .done_i        (done),
        .pending_any_o (pending_any),
        .pick_o        (pick),
        .ready_o       (ready_o),
        .overrun_o     (overrun_o)
    );

    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
            assign lab_ch[gi] = lab_dat_i[gi*DBITS +: DBITS];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        samp_next  = samp_reg;
        ch_next    = ch_reg;
        base_next  = base_reg;
        sel_next   = sel_reg;
        buf_next   = buf_reg;
        take       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pending_any) begin
                    take       = 1'b1;
                    buf_next   = pick;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_next   = '0;
                state_next = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (cnt_reg == CNT_W'(CONV_CYCLES - 1)) begin
                    cnt_next   = '0;
                    samp_next  = '0;
                    sel_next   = '0;
                    state_next = ST_SELECT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_SELECT: begin
                if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_CAPTURE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CAPTURE: begin
                ch_next    = '0;
                base_next  = '0;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (ch_reg == CH_W'(NCHAN - 1)) begin
                    if (samp_reg == SAMP_W'(NSAMP - 1)) begin
                        state_next = ST_DONE;
                    end else begin
                        // sel_o moves together with the sample index so the
                        // settle window starts on entry to SELECT.
                        samp_next  = samp_reg + 1'b1;
                        sel_next   = SEL_W'(samp_reg + 1'b1);
                        state_next = ST_SELECT;
                    end
                end else begin
                    ch_next   = ch_reg + 1'b1;
                    base_next = base_reg + WORD_W'(NSAMP);
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            samp_reg  <= '0;
            ch_reg    <= '0;
            base_reg  <= '0;
            sel_reg   <= '0;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            samp_reg  <= samp_next;
            ch_reg    <= ch_next;
            base_reg  <= base_next;
            sel_reg   <= sel_next;
            buf_reg   <= buf_next;
        end
    end

    // All channels are frozen at once so the write burst sees one sample.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (rst_i) begin
                hold_reg[i] <= '0;
            end else if (state_reg == ST_CAPTURE) begin
                hold_reg[i] <= lab_ch[i];
            end
        end
    end

    always_comb begin
        ram_we_o   = (state_reg == ST_WRITE);
        ram_addr_o = '0;
        ram_dat_o  = '0;
        if (ram_we_o) begin
            ram_addr_o = {buf_reg, base_reg + WORD_W'(samp_reg)};
            ram_dat_o  = DAT_W'(hold_reg[ch_reg]);
        end
    end

    assign wclr_o = (state_reg == ST_CLEAR);
    assign ramp_o = (state_reg == ST_CONVERT);
    assign busy_o = (state_reg != ST_IDLE);
    assign buf_o  = buf_reg;
    assign sel_o  = sel_reg;

endmodule

// File: doc/lab_readout_seq.md
Name: lab_readout_seq

Overview:
- Upstream neighbour of the LPC-bus/event interface.
- Takes per-buffer digitize strobes from the command receiver and runs the LAB Wilkinson conversion. Walks the sample/channel space and writes 16-bit samples into the LAB readout RAM, whose 32-bit port the bus interface reads.
- Raises a per-buffer ready flag once a buffer is fully written. The flag is cleared by the bus interface's event-clear.

Parameters:
- NCHAN, 12, LAB channels digitized in parallel.
- NSAMP, 256, samples per channel per buffer; NCHAN*NSAMP = 3072 words per buffer.
- DBITS, 12, Wilkinson result width per channel.
- CONV_CYCLES, 1024, ramp_o high time (Wilkinson conversion window).
- SETTLE_CYCLES, 4, wait after sel_o change before capture.

Ports:
- clk_i  in  1  33 MHz system clock.
- rst_i  in  1  synchronous, active-high reset.
- digitize_i  in  4  one-cycle strobe per buffer (bit n = buffer n).
- clr_buf_i  in  1  one-cycle strobe; clears ready flag of buffer clr_sel_i.
- clr_sel_i  in  2  buffer index for clr_buf_i.
- lab_dat_i  in  NCHAN*DBITS  parallel Wilkinson results; channel c at [c*DBITS +: DBITS].
- ramp_o  out  1  Wilkinson ramp/counter enable to LAB.
- wclr_o  out  1  one-cycle Wilkinson counter clear.
- buf_o  out  2  buffer being converted (LAB storage select).
- sel_o  out  8  sample select to LAB.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  14  {buffer[1:0], ch*NSAMP + samp} (12-bit field).
- ram_dat_o  out  16  {4'b0, sample[11:0]}.
- ready_o  out  4  per-buffer data-ready flags.
- busy_o  out  1  high whenever state != IDLE.
- overrun_o  out  1  sticky; set when a strobe hits a pending/active/ready buffer.

Behaviour:
- Reset (rst_i high at clk edge): state IDLE; pending, ready_o, overrun_o, counters cleared; all outputs 0. Reset mid-conversion abandons the buffer; no partial ready is set.
- pending[3:0] register: digitize_i[n] sets pending[n] unless buffer n is pending, active or ready. In that case the strobe is dropped and overrun_o is set. Multiple simultaneous strobes all accepted.
- FSM states: IDLE, CLEAR, CONVERT, SELECT, CAPTURE, WRITE, DONE.
- IDLE: if any pending, pick lowest index b, latch to buf_o, clear pending[b], go to CLEAR.
- CLEAR: wclr_o=1 for exactly 1 cycle, then CONVERT.
- CONVERT: ramp_o=1 for exactly CONV_CYCLES cycles; samp=0; then SELECT.
- SELECT: sel_o=samp; wait SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE: register full lab_dat_i into a holding bank in 1 cycle; ch=0; then WRITE.
- WRITE: one word per cycle for NCHAN cycles, with ram_we_o=1, ram_addr_o={b, ch*NSAMP+samp}, ram_dat_o = holding[ch].
  - After ch=NCHAN-1: if samp==NSAMP-1 go to DONE, else samp+1 and go to SELECT.
- DONE: ready_o[b] set; 1 cycle; back to IDLE.
- Per-sample cost is SETTLE_CYCLES+1+NCHAN. Total latency from the IDLE pick to ready is 1+CONV_CYCLES+NSAMP*(SETTLE_CYCLES+1+NCHAN)+1 cycles.
- ready_o[n] cleared by clr_buf_i with clr_sel_i==n. If clear and set of the same bit land in the same cycle, set wins.
- clr_buf_i aimed at the active or a pending buffer has no effect.
- Address math: ch*NSAMP done as an incrementing base register (+NSAMP per channel), not a multiplier; 12-bit, no wrap for defaults (max 3071).
- sel_o holds its value outside SELECT..WRITE; ram_we_o is 0 outside WRITE.

Decomposition:
- Shared package: FSM state encodings, default NCHAN/NSAMP/DBITS, RAM address width (14), buffer count (4).
- One natural sub-module, lab_buf_tracker: pending/ready/overrun bookkeeping plus the lowest-index picker. The FSM and datapath stay in the parent.

Test Plan:
- Single strobe digitize_i=4'b0100 -> wclr_o 1 cycle, ramp_o 1024 cycles, 3072 writes with ram_addr_o 0x2000..0x2BFF all hit. ready_o=4'b0100 exactly 1+1024+256*17+1 cycles after the pick. lab_dat_i pattern ch*16+sel_o is verified in RAM.
- Simultaneous digitize_i=4'b1010 -> buffer 1 converted first, then buffer 3. ready_o goes 0010, then 1010; overrun_o stays 0.
- Strobe buffer 1 while it is active, and again while ready -> overrun_o=1 sticky, no extra conversion.
- Later clr_buf_i with clr_sel_i=1 clears ready_o[1]; a new strobe is then accepted.
- rst_i asserted at write #100 of buffer 0 -> next cycle everything is 0 (busy_o=0, ready_o=0, ram_we_o=0). A new digitize_i=4'b0001 then restarts from CLEAR.
- clr_buf_i for buffer 2 in the same cycle DONE sets ready_o[2] -> ready_o[2]=1.
